// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, register offsets, CTRL layout and mode codes for timer_dev.
// Prescaler width is also used by timer_prescaler (built only with TIMER_PRESCALE_EN).
package timer_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_PRESET = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IM   = 3;
    localparam int CTRL_PRE  = 4;
    localparam int PRE_W     = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_AUTO    = 2'd1;

    function automatic logic is_auto(input logic [1:0] mode);
        return mode == MODE_AUTO;
    endfunction
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: emits a one-cycle tick every p+1 cycles; clr holds it at phase 0.
// Instantiated by timer_dev only when TIMER_PRESCALE_EN is defined.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [PRE_W-1:0] p,
    output logic             tick
);
    logic [PRE_W-1:0] cnt;

    // >= keeps the divider from running the long way round if p shrinks mid-count
    assign tick = !clr && cnt >= p;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else
            cnt <= (clr || tick) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer (CTRL/PRESET/COUNT) with interrupt output.
// Define TIMER_PRESCALE_EN to enable the CTRL[7:4] prescale field.
module timer_dev
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  A,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        IRQ
);
    state_t           state, state_n;
    logic [7:0]       ctrl;
    logic [CNT_W-1:0] preset, count, count_n;
    logic             irq_pend, set_pend, tick;
    logic             en, im, auto_md, ctrl_wr, preset_wr;

    assign en        = ctrl[CTRL_EN];
    assign im        = ctrl[CTRL_IM];
    assign auto_md   = is_auto(ctrl[CTRL_MODE +: 2]);
    assign ctrl_wr   = WE && A == TMR_CTRL;
    assign preset_wr = WE && A == TMR_PRESET;

`ifdef TIMER_PRESCALE_EN
    localparam logic [7:0] CTRL_MASK = 8'hFF;
    timer_prescaler u_pre (
        .clk  (clk),
        .reset(reset),
        .clr  (state == LOAD || !en),
        .p    (ctrl[CTRL_PRE +: PRE_W]),
        .tick (tick)
    );
`else
    localparam logic [7:0] CTRL_MASK = 8'h0F;
    assign tick = 1'b1;
`endif

    always_comb begin
        state_n  = state;
        count_n  = count;
        set_pend = 1'b0;
        case (state)
            IDLE: state_n = en ? LOAD : IDLE;
            LOAD: begin
                count_n = preset;
                state_n = CNT;
            end
            CNT: begin
                if (!en)
                    state_n = IDLE;
                else if (tick && count == '0) begin
                    state_n  = INT;
                    set_pend = !auto_md;
                end else if (tick)
                    count_n = count - 1'b1;
            end
            default: state_n = (auto_md && en) ? LOAD : IDLE;
        endcase
    end

    // A same-edge bus write to CTRL overrides the one-shot EN clear; a pend set beats a clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_pend <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            ctrl     <= ctrl_wr ? WD[7:0] & CTRL_MASK
                      : set_pend ? ctrl & ~(8'd1 << CTRL_EN) : ctrl;
            preset   <= preset_wr ? WD[CNT_W-1:0] : preset;
            irq_pend <= set_pend || (irq_pend && !(ctrl_wr || preset_wr));
        end
    end

    assign IRQ = im && (irq_pend || (state == INT && auto_md));

    assign RD = A == TMR_CTRL   ? {24'd0, ctrl}
              : A == TMR_PRESET ? 32'(preset)
              : A == TMR_COUNT  ? 32'(count)
              : 32'd0;
endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped countdown timer that responds on the processor bus driven by the CPU's `PrA`/`PrWE`/`PrWD`/`PrRD`. It raises an interrupt line that the system wires into one `HWInt` bit. The system bridge decodes the timer's address window and presents the word offset, write strobe, write data and read-data return. The block provides three word registers:

* `CTRL` at offset 0x0
* `PRESET` at offset 0x4
* `COUNT` at offset 0x8, read-only

## Interface
Parameters:
- `CNT_W`, default 32: width of `PRESET` and `COUNT`. Values are zero-extended onto `RD`.

Ports:
- `clk` in 1: sole clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `A` in 2: word offset, i.e. `PrA[3:2]`. Values: 0 = `CTRL`, 1 = `PRESET`, 2 = `COUNT`, 3 = unused.
- `WE` in 1: write strobe, already qualified by the bridge's address decode.
- `WD` in 32: write data.
- `RD` out 32: combinational read of the register selected by `A`.
- `IRQ` out 1: interrupt request to `HWInt`.

## Operation
- `CTRL` fields:
  - [0] `EN`
  - [2:1] `MODE`: 0 = one-shot, 1 = auto-reload, 2/3 behave as 0
  - [3] `IM`: interrupt mask, 1 = enabled
  - Undefined bits read 0.
- Writes:
  - `CTRL` and `PRESET` are loaded from `WD` at the edge where `WE` is high.
  - Writes to `COUNT` or offset 3 are ignored.
  - Offset 3 reads 0.
- FSM states: `IDLE`, `LOAD`, `CNT`, `INT`.
  - `IDLE`: goes to `LOAD` when `EN`=1.
  - `LOAD`: `COUNT`<=`PRESET`, then goes to `CNT`.
  - `CNT`:
    - If `EN`=0, go to `IDLE` with `COUNT` held.
    - Else if `COUNT`==0, go to `INT`.
    - Else `COUNT`<=`COUNT`-1.
  - `INT`, mode 0:
    - Entering `INT` clears `EN` and sets `irq_pend`.
    - Next state is `IDLE`.
  - `INT`, mode 1: next state is `LOAD` if `EN`=1, else `IDLE`.
- `IRQ` = `IM` & (`irq_pend` | (state==`INT` & `MODE`==1)).
- `irq_pend` is cleared by any write to `CTRL` or `PRESET`.
- Writing `PRESET` during `CNT` does not alter `COUNT`; the new value takes effect at the next `LOAD`.
- Re-enabling after a disable always passes through `LOAD`; there is no resume.

## Timing
- Reset values (asynchronous, immediate): `CTRL`=0, `PRESET`=0, `COUNT`=0, state `IDLE`, `irq_pend`=0, prescaler=0. `IRQ`=0 and `RD`=0 at every offset.
- Read latency is zero: `RD` reflects register contents before the current edge.
- Counter start, with `PRESET`=N and `EN` written at edge e0:
  - e1: `LOAD`.
  - e2: `COUNT`=N.
  - e2+N: `COUNT`=0.
  - e3+N: `INT`, `IRQ` rises.
- Mode 1 period is N+3 cycles, with `IRQ` high for exactly 1 of them.
- `COUNT`==0 in `CNT` never underflows; wrap-around is impossible.
- Collisions on the same edge:
  - Bus write to `CTRL` while the FSM clears `EN`: the bus write wins.
  - FSM sets `irq_pend` while a bus write clears it: the set wins, so no interrupt is lost.
- Async reset mid-count: all state returns to reset values immediately. Counting restarts only after a new `EN` write.

## Configuration
- `TIMER_PRESCALE_EN` defined:
  - `CTRL[7:4]` is a prescale field P.
  - In `CNT`, `COUNT` decrements, or the `COUNT`==0 test is taken, only on ticks every P+1 cycles.
  - The prescaler resets to 0 on `LOAD` and on disable.
  - Mode 1 period is (N+1)(P+1)+2.
- `TIMER_PRESCALE_EN` undefined:
  - Every cycle is a tick.
  - `CTRL[7:4]` reads 0 and ignores writes.

## Structure
- Shared package/header `timer_pkg`:
  - state encoding
  - offset constants `TMR_CTRL`, `TMR_PRESET`, `TMR_COUNT`
  - `CTRL` bit positions
  - mode constants
- Sub-module `timer_prescaler`, instantiated only under `TIMER_PRESCALE_EN`. Inputs: `clk`, `reset`, clear, P. Output: a one-cycle `tick` pulse.

## Test plan
- Reset: deassert reset, read offsets 0/1/2/3 -> all 0, `IRQ`=0.
- One-shot:
  - `PRESET`=3, then `CTRL`=0x9.
  - `COUNT` reads 3,2,1,0.
  - `IRQ` rises 6 edges after the `CTRL` write, and `CTRL` reads 0x8.
  - `IRQ` stays 1 until `CTRL`=0x8 is written, then falls next cycle.
- Auto-reload:
  - `PRESET`=2, `CTRL`=0xB.
  - `IRQ` gives one-cycle pulses every 5 cycles.
  - `CTRL`=0xA stops pulses after at most one more.
- Masked pend:
  - `PRESET`=1, `CTRL`=0x1.
  - After expiry `IRQ`=0.
  - Then writing `CTRL`=0x8 clears pend, so `IRQ` stays 0. Separately, an `IM` set via bit 3 in the same write as no clear is not possible; this check covers the clear-wins-only-without-set rule.
- Disable mid-count:
  - `PRESET`=10, enable, write `CTRL`=0 when `COUNT`=5.
  - `COUNT` holds 5, no `IRQ`.
  - Re-enable: `COUNT` reloads 10.
- Collision and reset:
  - Write `CTRL` on the edge the FSM enters `INT` -> `IRQ` follows the new `IM` with pend set.
  - Assert reset while `COUNT`=4 -> all registers 0 without waiting for `clk`.
